// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: issues PC fetches to imem and queues responses in a DEPTH-entry FIFO.
// Optional MISALIGN_CHECK_EN: misaligned PCs skip imem and enqueue a flagged marker entry.
`timescale 1ns/1ps
module fetch_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        pc_valid,
  output logic        pc_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        flush,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        inst_misalign
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, SQUASH = 2'd2} state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
`ifdef MISALIGN_CHECK_EN
    logic        mis;
`endif
  } entry_t;

  state_t      state, stateNxt;
  logic [PW:0] count;
  logic [PW-1:0] wrPtr, rdPtr;
  logic [31:0] reqPc;
  entry_t      mem [DEPTH];
  entry_t      head, wrEntry;
  logic        creditOk, misPc, accept, rspArr, push, pop, hasHead;

  // count plus the single possible in-flight fetch must leave room in the FIFO
  assign creditOk = (32'(count) + 32'(state != IDLE)) < DEPTH;

`ifdef MISALIGN_CHECK_EN
  logic reqMis;
  assign misPc  = pc_in[1:0] != 2'b00;
  // a misaligned fetch "responds" internally one cycle after accept, keeping program order
  assign rspArr = reqMis | imem_rvalid;
`else
  assign misPc  = 1'b0;
  assign rspArr = imem_rvalid;
`endif

  assign pc_ready   = ~rst & creditOk & ~flush & (imem_gnt | misPc);
  assign imem_req   = ~rst & pc_valid & creditOk & ~flush & ~misPc;
  assign imem_addr  = pc_in;
  assign accept     = pc_valid & pc_ready;
  assign hasHead    = count != '0;
  assign inst_valid = hasHead & ~flush;
  assign pop        = inst_valid & inst_ready;
  assign push       = (state == BUSY) & rspArr & ~flush;

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE: if (accept) stateNxt = BUSY;
      BUSY, SQUASH: begin
        // a response arriving with the flush is the in-flight one: it is dropped right here
        if (flush)       stateNxt = rspArr ? IDLE : SQUASH;
        else if (rspArr) stateNxt = accept ? BUSY : IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
      reqPc <= '0;
`ifdef MISALIGN_CHECK_EN
      reqMis <= 1'b0;
`endif
    end else begin
      state <= stateNxt;
      if (accept) begin
        reqPc <= pc_in;
`ifdef MISALIGN_CHECK_EN
        reqMis <= misPc;
`endif
      end
      if (flush) begin
        count <= '0;
        wrPtr <= '0;
        rdPtr <= '0;
      end else begin
        if (push) wrPtr <= wrPtr + PW'(1);
        if (pop)  rdPtr <= rdPtr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + (PW+1)'(1);
          2'b01:   count <= count - (PW+1)'(1);
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    wrEntry      = '0;
    wrEntry.inst = imem_rdata;
    wrEntry.pc   = reqPc;
`ifdef MISALIGN_CHECK_EN
    wrEntry.mis  = reqMis;
    if (reqMis) wrEntry.inst = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= wrEntry;
  end

  assign head     = mem[rdPtr];
  // head fields are forced to zero while empty so reset shows clean outputs
  assign inst_out = hasHead ? head.inst : '0;
  assign inst_pc  = hasHead ? head.pc   : '0;
`ifdef MISALIGN_CHECK_EN
  assign inst_misalign = hasHead & head.mis;
`else
  assign inst_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// Scoreboard bench for fetch_buffer: stimulus queues expected entries, a monitor pops on each handshake.
`timescale 1ns/1ps
module tb_fetch_buffer;
  localparam int DEPTH = 4;

  logic        clk = 0, rst = 1;
  logic [31:0] pc_in = 0;
  logic        pc_valid = 0, pc_ready, imem_req, imem_gnt = 0;
  logic [31:0] imem_addr;
  logic        memRv = 0;
  logic [31:0] memRd = 0, memData = 0;
  logic        flush = 0, inst_valid, inst_ready = 0, inst_misalign;
  logic [31:0] inst_out, inst_pc;

  int checks = 0, errors = 0, cyc = 0, accCnt = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        mis;
    int          rdyCyc;
  } exp_t;
  exp_t expQ[$];

  fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(memRv), .imem_rdata(memRd), .flush(flush),
    .inst_out(inst_out), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_misalign(inst_misalign)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // memory: answers exactly one cycle after req&gnt; not reset, so a stale response can follow a reset
  always @(posedge clk) begin
    memRv <= imem_req & imem_gnt;
    memRd <= (imem_req & imem_gnt) ? memData : $urandom;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic isMis(input logic [31:0] pc);
`ifdef MISALIGN_CHECK_EN
    return pc[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  // one cycle of stimulus; model: occupancy = buffered + in-flight = expQ.size()
  task automatic step(input logic pcv, input logic [31:0] pc, input logic gnt,
                      input logic rdy, input logic fl, input logic [31:0] data);
    logic mis, room;
    @(negedge clk);
    pc_valid = pcv; pc_in = pc; imem_gnt = gnt; inst_ready = rdy; flush = fl; memData = data;
    #1;
    mis  = isMis(pc);
    room = expQ.size() < DEPTH;
    chk("pc_ready", 32'(pc_ready), 32'(!fl && room && (gnt || mis)));
    chk("imem_req", 32'(imem_req), 32'(pcv && !fl && room && !mis));
    chk("imem_addr", imem_addr, pc);
    if (fl) expQ.delete();
    else if (pcv && pc_ready) begin
      accCnt++;
      expQ.push_back('{pc: pc, inst: mis ? 32'h0 : data, mis: mis, rdyCyc: cyc + 2});
    end
  endtask

  task automatic chkResetOutputs(input string tag);
    chk({tag, ".pc_ready"},  32'(pc_ready), 0);
    chk({tag, ".imem_req"},  32'(imem_req), 0);
    chk({tag, ".inst_valid"}, 32'(inst_valid), 0);
    chk({tag, ".inst_out"},  inst_out, 0);
    chk({tag, ".inst_pc"},   inst_pc, 0);
    chk({tag, ".inst_misalign"}, 32'(inst_misalign), 0);
  endtask

  // asynchronous reset pulse inside one cycle, while a response is on the bus
  task automatic rstPulse();
    @(negedge clk);
    pc_valid = 1; pc_in = 32'h40; imem_gnt = 1; inst_ready = 1; flush = 0;
    #2 rst = 1;
    #1 chkResetOutputs("midreset");
    expQ.delete();
    rst = 0;
    pc_valid = 0;
  endtask

  // monitor
  initial begin
    logic expV;
    forever begin
      @(negedge clk);
      #4;
      if (!rst) begin
        expV = !flush && expQ.size() > 0 && expQ[0].rdyCyc <= cyc;
        chk("inst_valid", 32'(inst_valid), 32'(expV));
        if (inst_valid && expV) begin
          chk("inst_pc", inst_pc, expQ[0].pc);
          chk("inst_out", inst_out, expQ[0].inst);
          chk("inst_misalign", 32'(inst_misalign), 32'(expQ[0].mis));
          if (inst_ready) void'(expQ.pop_front());
        end
      end
    end
  end

  initial begin
    pc_valid = 1; imem_gnt = 1; inst_ready = 1;
    #3 chkResetOutputs("reset");
    @(negedge clk); @(negedge clk);
    #2 rst = 0;
    pc_valid = 0;

    // back-to-back fetches, consumer always ready
    step(1, 32'h0, 1, 1, 0, 32'hA);
    step(1, 32'h4, 1, 1, 0, 32'hB);
    step(1, 32'h8, 1, 1, 0, 32'hC);
    repeat (4) step(0, 32'h0, 1, 1, 0, 32'h0);

    // backpressure: exactly DEPTH accepts, then one pop frees one slot
    accCnt = 0;
    for (int i = 0; i < 6; i++) step(1, 32'h100 + 32'(i * 4), 1, 0, 0, $urandom);
    chk("accepts_when_full", 32'(accCnt), 4);
    step(0, 32'h0, 1, 1, 0, 32'h0);
    for (int i = 0; i < 3; i++) step(1, 32'h200 + 32'(i * 4), 1, 0, 0, $urandom);
    chk("accepts_after_pop", 32'(accCnt), 5);
    repeat (6) step(0, 32'h0, 1, 1, 0, 32'h0);

    // flush right after accepting 0x10: 0xDEAD must never surface
    step(1, 32'h10, 1, 1, 0, 32'hDEAD);
    step(1, 32'h14, 1, 1, 1, 32'h0);
    step(0, 32'h0, 1, 1, 0, 32'h0);
    step(0, 32'h0, 1, 1, 0, 32'h0);

    // grant withheld for three cycles, then granted
    repeat (3) step(1, 32'h20, 0, 1, 0, 32'h5);
    step(1, 32'h20, 1, 1, 0, 32'h55);
    repeat (3) step(0, 32'h0, 1, 1, 0, 32'h0);

    // reset while busy with a full FIFO; the trailing response must be ignored
    for (int i = 0; i < 4; i++) step(1, 32'h300 + 32'(i * 4), 1, 0, 0, $urandom);
    rstPulse();
    repeat (4) step(0, 32'h0, 1, 1, 0, 32'h0);

`ifdef MISALIGN_CHECK_EN
    step(1, 32'h4, 1, 1, 0, 32'h44);
    step(1, 32'h6, 1, 1, 0, 32'h66);
    repeat (3) step(0, 32'h0, 1, 1, 0, 32'h0);
`endif

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] pc;
      pc = $urandom & 32'hFFFF_FFFC;
`ifdef MISALIGN_CHECK_EN
      if ($urandom_range(0, 9) == 0) pc[1:0] = 2'($urandom_range(1, 3));
`endif
      step($urandom_range(0, 9) < 8, pc, $urandom_range(0, 3) != 0,
           $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0, $urandom);
    end
    repeat (8) step(0, 32'h0, 1, 1, 0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the instruction FIFO entry count (power of two, 2..16).
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port pc_in  in  32  fetch address from the PC register.
REQ-005 SHALL have port pc_valid  in  1  pc_in is valid.
REQ-006 SHALL have port pc_ready  out  1  the PC is accepted this cycle; the PC register advances only when this is high.
REQ-007 SHALL have port imem_req  out  1  instruction-memory read request.
REQ-008 SHALL have port imem_addr  out  32  request address, equal to pc_in.
REQ-009 SHALL have port imem_gnt  in  1  memory accepts the request.
REQ-010 SHALL have port imem_rvalid  in  1  read data valid.
REQ-011 SHALL have port imem_rdata  in  32  read data.
REQ-012 SHALL have port flush  in  1  pipeline redirect; discard all buffered and in-flight fetches.
REQ-013 SHALL have ports inst_out/inst_pc  out  32 each  head instruction and its PC.
REQ-014 SHALL have port inst_valid  out  1  the FIFO head is valid.
REQ-015 SHALL have port inst_ready  in  1  the consumer takes the head.
REQ-016 SHALL have port inst_misalign  out  1  the head was a misaligned-PC entry.

Function
REQ-017 SHALL define accept = pc_valid & pc_ready; the memory SHALL return rvalid exactly 1 cycle after the cycle with imem_req & imem_gnt.
REQ-018 SHALL compute credit_ok = (count + outstanding) < DEPTH from registered state only, where outstanding is 0 or 1.
REQ-019 SHALL drive imem_req = pc_valid & credit_ok & ~flush (aligned PC only when MISALIGN_CHECK_EN is defined) and pc_ready = credit_ok & ~flush & imem_gnt.
REQ-020 SHALL implement FSM IDLE (0 outstanding), BUSY (1 outstanding), SQUASH (1 outstanding, to be dropped).
REQ-021 SHALL move IDLE->BUSY on accept; in BUSY, rvalid plus a new accept stays BUSY, and rvalid without an accept goes to IDLE.
REQ-022 SHALL, in BUSY or SQUASH with flush, go to SQUASH; SQUASH SHALL drop the next rvalid and go to IDLE.
REQ-023 SHALL push {imem_rdata, captured PC} into the FIFO on rvalid in BUSY; a push SHALL be visible on inst_valid the next cycle (fetch-to-output latency 2 cycles).
REQ-024 SHALL pop on inst_valid & inst_ready; a simultaneous push and pop SHALL keep count unchanged, with pointers wrapping modulo DEPTH.
REQ-025 SHALL drive inst_valid = (count != 0) & ~flush.
REQ-026 SHALL, on flush, clear count and pointers at the clock edge, ignore any same-cycle accept, pop or rvalid, and discard the in-flight response.
REQ-027 SHALL give flush priority over all other events in the same cycle.
REQ-028 SHALL sustain throughput of 1 instruction per cycle when imem_gnt=1 and the consumer is always ready.

Reset
REQ-029 SHALL, on rst assertion, immediately set FSM=IDLE, count=0, pointers=0, imem_req=0, pc_ready=0, inst_valid=0, and inst_out=inst_pc=0 with inst_misalign=0.
REQ-030 SHALL, on reset mid-operation, silently discard the outstanding response, and no rvalid SHALL be consumed during the first cycle after reset.

Configuration
REQ-031 SHALL, with MISALIGN_CHECK_EN defined, treat pc_in[1:0]!=0 as misaligned: pc_ready = credit_ok & ~flush, imem_req=0, and one cycle after accept push an entry {inst=0, pc=pc_in, misalign=1} while preserving program order.
REQ-032 SHALL, without MISALIGN_CHECK_EN, ignore pc_in[1:0] for checking, tie inst_misalign to 0, and have no misalign FIFO storage.

Verification
REQ-033 SHALL cover: reset, then pc 0x0,0x4,0x8 with gnt=1, rdata=0xA,0xB,0xC, and inst_ready=1 -> inst_valid from cycle 2, and outputs (0x0,0xA),(0x4,0xB),(0x8,0xC) on consecutive cycles.
REQ-034 SHALL cover: inst_ready=0 and DEPTH=4 with continuous PCs -> exactly 4 accepts, then pc_ready=0; one pop -> exactly one further accept.
REQ-035 SHALL cover: flush in the cycle after accepting pc 0x10 with rdata 0xDEAD -> 0xDEAD never appears, and inst_valid=0 for 2 cycles.
REQ-036 SHALL cover: imem_gnt=0 for 3 cycles with pc_valid=1 -> pc_ready=0 and no FIFO change; gnt=1 -> accept on the next edge.
REQ-037 SHALL cover: rst pulsed while BUSY with a full FIFO -> all outputs 0 at once, and a later rvalid ignored.
REQ-038 SHALL cover, with MISALIGN_CHECK_EN: pc 0x6 after 0x4 -> imem_req=0 for 0x6, and entries (0x4,data,0),(0x6,0,1) in order.
